// File: rtl/cam_capture.sv
// OV7670 capture: packs camera byte pairs into RGB444 pixels and writes them to the frame buffer.
// Define CAM_CAPTURE_CONTINUOUS_EN to capture back-to-back frames while start stays high.
module cam_capture #(
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 640*480
) (
   input  logic                     p_clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     vsync,
   input  logic                     href,
   input  logic [7:0]               p_data,
   output logic                     w_en,
   output logic [$clog2(DEPTH)-1:0] w_addr,
   output logic [DATA_WIDTH-1:0]    w_din,
   output logic                     frame_done,
   output logic                     overflow,
   output logic                     busy
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

   state_t      state, next_state;
   logic        vsync_q, vsync_prev, href_q;
   logic [7:0]  data_q;
   logic        phase, addr_full;
   logic [3:0]  r_nib;
   logic        vsync_fall, vsync_rise;
   logic        first_byte, pixel_done, frame_end, new_frame;

   // vsync history resets high so no edge is seen before the bus is really sampled
   always_ff @(posedge p_clk or negedge rstn) begin
      if (!rstn) begin
         vsync_q    <= 1'b1;
         vsync_prev <= 1'b1;
         href_q     <= 1'b0;
         data_q     <= 8'h00;
      end else begin
         vsync_q    <= vsync;
         vsync_prev <= vsync_q;
         href_q     <= href;
         data_q     <= p_data;
      end
   end

   assign vsync_fall = vsync_prev & ~vsync_q;
   assign vsync_rise = ~vsync_prev & vsync_q;

   always_ff @(posedge p_clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start) next_state = WAIT_SOF;
         WAIT_SOF: if (vsync_fall) next_state = CAPTURE;
         CAPTURE: begin
            if (vsync_rise) begin
`ifdef CAM_CAPTURE_CONTINUOUS_EN
               next_state = start ? WAIT_SOF : IDLE;
`else
               next_state = IDLE;
`endif
            end
         end
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      first_byte = (state == CAPTURE) && href_q && !phase;
      pixel_done = (state == CAPTURE) && href_q && phase;
      frame_end  = (state == CAPTURE) && vsync_rise;
      new_frame  = (next_state == WAIT_SOF) && (state != WAIT_SOF);
   end

   // A pixel finishing on the end-of-frame edge is still written; its write cycle then zeroes w_addr
   always_ff @(posedge p_clk or negedge rstn) begin
      if (!rstn) begin
         phase      <= 1'b0;
         r_nib      <= 4'h0;
         w_en       <= 1'b0;
         w_addr     <= '0;
         w_din      <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         addr_full  <= 1'b0;
      end else begin
         frame_done <= frame_end;
         w_en       <= pixel_done && !addr_full;
         phase      <= (state == CAPTURE && href_q && !frame_end) ? ~phase : 1'b0;
         if (first_byte) r_nib <= data_q[3:0];
         if (pixel_done) begin
            if (addr_full) overflow <= 1'b1;
            else           w_din    <= {r_nib, data_q};
         end
         if (w_en) begin
            if (state != CAPTURE)        w_addr    <= '0;
            else if (w_addr == LAST_ADDR) addr_full <= 1'b1;
            else                         w_addr    <= w_addr + AW'(1);
         end
         if (frame_end && !pixel_done) w_addr <= '0;
         if (new_frame) begin
            addr_full <= 1'b0;
            overflow  <= 1'b0;
            if (!pixel_done) w_addr <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with an 8-pixel frame buffer.
module tb_cam_capture;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          p_clk = 1'b0;
   logic          rstn, start, vsync, href;
   logic [7:0]    p_data;
   logic          w_en, frame_done, overflow, busy;
   logic [AW-1:0] w_addr;
   logic [11:0]   w_din;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [AW-1:0] wr_addr_q[$];
   logic [11:0]   wr_data_q[$];
   int            done_cnt  = 0;
   int            b2b_cnt   = 0;
   logic          w_en_prev = 1'b0;

`ifdef CAM_CAPTURE_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   cam_capture #(.DATA_WIDTH(12), .DEPTH(DEPTH)) dut (
      .p_clk(p_clk), .rstn(rstn), .start(start), .vsync(vsync), .href(href),
      .p_data(p_data), .w_en(w_en), .w_addr(w_addr), .w_din(w_din),
      .frame_done(frame_done), .overflow(overflow), .busy(busy)
   );

   always #5 p_clk = ~p_clk;

   // Record every frame-buffer write and frame_done pulse, sampled mid-cycle
   always @(negedge p_clk) begin
      if (w_en) begin
         wr_addr_q.push_back(w_addr);
         wr_data_q.push_back(w_din);
      end
      if (w_en && w_en_prev) b2b_cnt++;
      w_en_prev = w_en;
      if (frame_done) done_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
      @(negedge p_clk);
      vsync  = v;
      href   = h;
      p_data = d;
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   // Even bytes carry R in the low nibble, odd bytes carry {G,B}
   task automatic camLine(input int nbytes, input int r0, input int rstep, input logic [7:0] gb);
      logic [3:0] r;
      for (int j = 0; j < nbytes; j++) begin
         r = 4'(r0 + rstep * (j / 2));
         if (j % 2 == 0) applyStimulus(1'b0, 1'b1, {4'h0, r});
         else            applyStimulus(1'b0, 1'b1, gb);
      end
   endtask

   task automatic pulseStart();
      @(negedge p_clk);
      start = 1'b1;
      @(negedge p_clk);
      start = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge p_clk);
      #2;
   endtask

   initial begin
      int  base, dbase;
      bit  seen;
      rstn = 1'b1; start = 1'b0; vsync = 1'b1; href = 1'b0; p_data = 8'h00;
      #1 rstn = 1'b0;
      #20;
      checkOutput("rst_w_en", w_en, 0);
      checkOutput("rst_w_addr", w_addr, 0);
      checkOutput("rst_w_din", w_din, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_busy", busy, 0);
      @(negedge p_clk) rstn = 1'b1;

      // Basic frame: 2 lines x 4 pixels of 0x0A,0xBC
      base = wr_addr_q.size(); dbase = done_cnt;
      pulseStart();
      settle(1);
      checkOutput("t1_busy", busy, 1);
      vblank(3); gap(2);
      camLine(8, 10, 0, 8'hBC); gap(3);
      camLine(8, 10, 0, 8'hBC); gap(2);
      vblank(5); settle(1);
      checkOutput("t1_writes", wr_addr_q.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < wr_addr_q.size()) begin
            checkOutput($sformatf("t1_addr%0d", i), wr_addr_q[base+i], i);
            checkOutput($sformatf("t1_data%0d", i), wr_data_q[base+i], 12'hABC);
         end
      end
      checkOutput("t1_done", done_cnt - dbase, 1);
      checkOutput("t1_overflow", overflow, 0);
      checkOutput("t1_busy_end", busy, 0);
      checkOutput("t1_addr_end", w_addr, 0);

      // Odd-length line: trailing byte dropped, next line realigned
      base = wr_addr_q.size(); dbase = done_cnt;
      pulseStart();
      vblank(2); gap(2);
      camLine(9, 1, 1, 8'h5A); gap(3);
      camLine(8, 6, 1, 8'h5A); gap(2);
      vblank(5); settle(1);
      checkOutput("t2_writes", wr_addr_q.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < wr_addr_q.size()) begin
            checkOutput($sformatf("t2_addr%0d", i), wr_addr_q[base+i], i);
            checkOutput($sformatf("t2_data%0d", i), wr_data_q[base+i],
                        {(i < 4) ? 4'(1 + i) : 4'(2 + i), 8'h5A});
         end
      end
      checkOutput("t2_done", done_cnt - dbase, 1);

      // Overlong frame: 10 pixels into 8 locations
      base = wr_addr_q.size(); dbase = done_cnt;
      pulseStart();
      vblank(2); gap(2);
      camLine(12, 0, 1, 8'h77); gap(3); settle(1);
      checkOutput("t3_ovf_early", overflow, 0);
      camLine(8, 6, 1, 8'h77); gap(3); settle(1);
      checkOutput("t3_ovf_set", overflow, 1);
      checkOutput("t3_addr_hold", w_addr, 7);
      vblank(5); settle(1);
      checkOutput("t3_writes", wr_addr_q.size() - base, 8);
      if (wr_addr_q.size() > 0) begin
         checkOutput("t3_last_addr", wr_addr_q[wr_addr_q.size()-1], 7);
         checkOutput("t3_last_data", wr_data_q[wr_data_q.size()-1], 12'h777);
      end
      checkOutput("t3_done", done_cnt - dbase, 1);
      checkOutput("t3_ovf_sticky", overflow, 1);
      checkOutput("t3_addr_end", w_addr, 0);
      checkOutput("t3_b2b", b2b_cnt, 0);

      // Start mid-frame: the running frame is ignored
      base = wr_addr_q.size(); dbase = done_cnt;
      vblank(3); gap(2);
      pulseStart();
      checkOutput("t4_ovf_clr", overflow, 0);
      camLine(8, 3, 0, 8'h44); gap(2);
      vblank(5); settle(1);
      checkOutput("t4_no_writes", wr_addr_q.size() - base, 0);
      checkOutput("t4_no_done", done_cnt - dbase, 0);
      checkOutput("t4_busy_wait", busy, 1);
      gap(2);
      camLine(8, 2, 1, 8'h99); gap(3);
      camLine(8, 6, 1, 8'h99); gap(2);
      vblank(5); settle(1);
      checkOutput("t4_writes", wr_addr_q.size() - base, 8);
      if (wr_addr_q.size() > base) begin
         checkOutput("t4_first_addr", wr_addr_q[base], 0);
         checkOutput("t4_first_data", wr_data_q[base], 12'h299);
      end
      checkOutput("t4_done", done_cnt - dbase, 1);

      // Reset mid-frame after 3 pixels
      base = wr_addr_q.size(); dbase = done_cnt;
      pulseStart();
      vblank(2); gap(2);
      camLine(6, 1, 1, 8'h33);
      #1 rstn = 1'b0;
      #1;
      checkOutput("t5_pre_writes", wr_addr_q.size() - base, 2);
      checkOutput("t5_w_en", w_en, 0);
      checkOutput("t5_w_addr", w_addr, 0);
      checkOutput("t5_w_din", w_din, 0);
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_frame_done", frame_done, 0);
      href = 1'b0;
      settle(2);
      @(negedge p_clk) rstn = 1'b1;
      vblank(5); settle(1);
      checkOutput("t5_no_done", done_cnt - dbase, 0);
      base = wr_addr_q.size();
      pulseStart();
      vblank(2); gap(2);
      camLine(4, 7, 0, 8'h11); gap(2);
      vblank(5); settle(1);
      checkOutput("t5_writes", wr_addr_q.size() - base, 2);
      if (wr_addr_q.size() > base) begin
         checkOutput("t5_first_addr", wr_addr_q[base], 0);
         checkOutput("t5_first_data", wr_data_q[base], 12'h711);
      end
      checkOutput("t5_done", done_cnt - dbase, 1);

      // Two frames with start held through the first end-of-frame
      base = wr_addr_q.size(); dbase = done_cnt;
      @(negedge p_clk) start = 1'b1;
      vblank(2); gap(2);
      camLine(8, 1, 1, 8'h22); gap(2);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         applyStimulus(1'b1, 1'b0, 8'h00);
         if (frame_done) seen = 1'b1;
      end
      start = 1'b0;
      checkOutput("t6_eof_seen", seen, 1);
      checkOutput("t6_busy_at_done", busy, CONT);
      vblank(3); settle(1);
      checkOutput("t6_busy_between", busy, CONT);
      gap(2);
      camLine(8, 9, 0, 8'h33); gap(2);
      vblank(5); settle(1);
      checkOutput("t6_writes", wr_addr_q.size() - base, CONT ? 8 : 4);
      checkOutput("t6_done", done_cnt - dbase, CONT ? 2 : 1);
      if (CONT && wr_addr_q.size() >= base + 5) begin
         checkOutput("t6_b_first_addr", wr_addr_q[base+4], 0);
         checkOutput("t6_b_first_data", wr_data_q[base+4], 12'h933);
      end
      checkOutput("t6_busy_end", busy, 0);
      checkOutput("t6_b2b", b2b_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cam_capture.md
# cam_capture

Pixel capture stage for the OV7670 path. Samples the camera's 8-bit parallel bus in the pixel-clock domain and assembles byte pairs into 12-bit RGB444 pixels. Drives the write port of the frame buffer with enable, address and data. Sequences frames from VSYNC/HREF and reports frame completion and overflow.

## Interface
- DATA_WIDTH, 12, pixel width written to frame buffer (fixed RGB444 packing, must be 12)
- DEPTH, 640*480, pixels per frame; address width is $clog2(DEPTH)
- p_clk  in  1  camera pixel clock (PCLK); sole clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  request capture; level-sampled in IDLE
- vsync  in  1  camera VSYNC, high during vertical blanking
- href  in  1  camera HREF, high while a line's bytes are valid
- p_data  in  8  camera D[7:0]
- w_en  out  1  frame-buffer write enable
- w_addr  out  $clog2(DEPTH)  frame-buffer write address
- w_din  out  DATA_WIDTH  pixel {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse at end of a captured frame
- overflow  out  1  sticky: frame delivered more than DEPTH pixels
- busy  out  1  high in any state other than IDLE

## Operation
- vsync, href, p_data registered once on p_clk (vsync_q, href_q, data_q); all decisions use registered copies.
- States: IDLE, WAIT_SOF, CAPTURE.
- IDLE: busy=0. start=1 -> WAIT_SOF; w_addr<=0, byte phase<=0, overflow<=0.
- WAIT_SOF: wait for vsync_q falling edge (1 -> 0), i.e. start of active frame; -> CAPTURE. A capture never begins mid-frame.
- CAPTURE: while href_q=1, byte phase toggles each cycle. Phase 0: latch data_q[3:0] as R. Phase 1: form pixel {R, data_q[7:4], data_q[3:0]}, assert w_en next cycle.
- href_q=0 forces byte phase to 0 (odd trailing byte in a line is discarded; next line realigns).
- After each write w_addr increments by 1. Write at address DEPTH-1 is the last accepted; further completed pixels set overflow=1, w_en stays 0, w_addr holds at DEPTH-1.
- vsync_q rising edge in CAPTURE: end of frame. frame_done pulses, w_addr<=0, -> IDLE (single-shot; see Configuration). Short frames (<DEPTH pixels) end identically; unwritten locations keep old content.
- Pixel completed in the same cycle as vsync_q rising: still written, then frame ends.
- start ignored outside IDLE.
- Reset mid-frame: immediate return to IDLE; the partial frame is abandoned; no frame_done.

## Timing
- Reset values: w_en=0, w_addr=0, w_din=0, frame_done=0, overflow=0, busy=0, state=IDLE, phase=0.
- Latency: second byte on p_data at edge N -> data_q at N -> w_en=1 with w_din/w_addr valid after edge N+1, for exactly one cycle.
- Max write rate: one pixel every 2 cycles; w_en never high on consecutive cycles.
- w_addr updates on the edge after the w_en cycle. w_addr is stable while w_en=1.
- frame_done is high in the cycle after the edge that sampled vsync_q rising; busy falls in that same cycle.
- Edge detect uses previous vsync_q value, which resets to 1 (no false SOF straight out of reset while vsync low).

## Configuration
- CAM_CAPTURE_CONTINUOUS_EN defined: at end of frame, if start=1 go directly to CAPTURE-wait (WAIT_SOF) without passing IDLE. Consecutive frames are captured back-to-back while start is held. overflow clears at each new frame.
- Undefined: single-shot; each frame requires start in IDLE.

## Test plan
- Reset then start=1, one frame of 2 lines x 4 pixels (DEPTH=8), bytes 0x0A,0xBC per pixel -> 8 writes, w_din=0xABC, w_addr 0..7, frame_done once, overflow=0.
- Line with odd byte count (9 bytes) followed by normal line -> 4 pixels from first line, second line pixels aligned correctly (no byte shift).
- DEPTH=8, frame of 10 pixels -> 8 writes, w_addr holds 7, overflow=1 at 9th pixel, frame_done pulses.
- start asserted mid-frame (vsync low) -> no writes until next vsync fall; then full frame captured from address 0.
- rstn pulled low after 3 pixels -> all outputs at reset values immediately, no frame_done; new start captures from address 0.
- With CAM_CAPTURE_CONTINUOUS_EN and start held, two frames -> two frame_done pulses, second frame writes restart at 0, busy stays 1 between frames; without macro, second frame produces no writes.
